// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache responder: FSM states, funct3 size
// codes, and lane/byte-enable/extension functions.
package dcache_pkg;

  localparam int XLEN       = 64;
  localparam int LANE_W     = 3;
  localparam int BYTE_LANES = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SZ_B   = 3'd0,
    SZ_H   = 3'd1,
    SZ_W   = 3'd2,
    SZ_D   = 3'd3,
    SZ_BU  = 3'd4,
    SZ_HU  = 3'd5,
    SZ_WU  = 3'd6,
    SZ_ILL = 3'd7
  } size_e;

  // Low address bits that must be zero for an access of this size; code 7 acts as dword.
  function automatic logic [LANE_W-1:0] size_mask(input logic [2:0] bits);
    case (bits[1:0])
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [LANE_W-1:0] align_lane(input logic [LANE_W-1:0] lane,
                                                   input logic [2:0] bits);
    return lane & ~size_mask(bits);
  endfunction

  function automatic logic misaligned(input logic [LANE_W-1:0] lane, input logic [2:0] bits);
    return (|(lane & size_mask(bits))) || (bits == SZ_ILL);
  endfunction

  function automatic logic [BYTE_LANES-1:0] byte_en(input logic [LANE_W-1:0] lane,
                                                    input logic [2:0] bits);
    logic [BYTE_LANES-1:0] base;
    case (bits[1:0])
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic [XLEN-1:0] store_shift(input logic [XLEN-1:0] data,
                                                  input logic [LANE_W-1:0] lane);
    return data << {lane, 3'b000};
  endfunction

  // bits[2] selects zero extension; bits[1:0] selects the access width.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [2:0] bits);
    logic [XLEN-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (bits[1:0])
      2'd0:    return bits[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    return bits[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return bits[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word-wide storage with per-byte write enables and registered read.
// Split into one 8-bit array per lane so each lane maps onto its own RAM column.
module sram_1rw #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) mem[addr] <= wdata[gi*8 +: 8];
        end else begin
          rd_q <= mem[addr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/dcache_resp.sv
// Fixed-latency data-cache responder: IDLE/BUSY/DONE sequencer around a 1RW RAM.
// Optional DCACHE_MISALIGN_TRAP_EN: misaligned or code-7 accesses complete with fault.
module dcache_resp
  import dcache_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dcache_r_rqst,
  input  logic [63:0]     dcache_r_addr,
  input  logic [2:0]      dcache_r_bits,
  output logic            dcache_r_done,
  output logic [63:0]     dcache_r_data,
  input  logic            dcache_w_rqst,
  input  logic [63:0]     dcache_w_addr,
  input  logic [2:0]      dcache_w_bits,
  input  logic [63:0]     dcache_w_data,
  output logic            dcache_w_done,
  output logic            fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IA = AW + LANE_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IA-1:0]     addr_q;
  logic [2:0]        bits_q;
  logic [XLEN-1:0]   wdata_q;
  logic              wr_q;

  logic              accept, enter_done, idle;
  logic              cur_wr, cur_bad, done_bad;
  logic [IA-1:0]     cur_addr;
  logic [2:0]        cur_bits;
  logic [XLEN-1:0]   cur_wdata;
  logic [LANE_W-1:0] cur_lane;
  logic [XLEN-1:0]   ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{dcache_r_addr[63:IA], dcache_w_addr[63:IA]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dcache_w_rqst || dcache_r_rqst) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            enter_done = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bits_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= cur_addr;
        bits_q  <= cur_bits;
        wdata_q <= cur_wdata;
        wr_q    <= cur_wr;
      end
    end
  end

  // In IDLE the RAM sees the live request so LATENCY=1 can commit on the accept edge.
  assign idle      = (state_q == ST_IDLE);
  assign cur_wr    = idle ? dcache_w_rqst : wr_q;
  assign cur_addr  = idle ? (dcache_w_rqst ? dcache_w_addr[IA-1:0] : dcache_r_addr[IA-1:0])
                          : addr_q;
  assign cur_bits  = idle ? (dcache_w_rqst ? dcache_w_bits : dcache_r_bits) : bits_q;
  assign cur_wdata = idle ? dcache_w_data : wdata_q;
  assign cur_lane  = align_lane(cur_addr[LANE_W-1:0], cur_bits);

`ifdef DCACHE_MISALIGN_TRAP_EN
  assign cur_bad  = misaligned(cur_addr[LANE_W-1:0], cur_bits);
  assign done_bad = misaligned(addr_q[LANE_W-1:0], bits_q);
`else
  assign cur_bad  = 1'b0;
  assign done_bad = 1'b0;
`endif

  sram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (enter_done && !cur_bad),
    .we    (cur_wr),
    .addr  (cur_addr[IA-1:LANE_W]),
    .be    (byte_en(cur_lane, cur_bits)),
    .wdata (store_shift(cur_wdata, cur_lane)),
    .rdata (ram_rdata)
  );

  assign dcache_w_done = (state_q == ST_DONE) && wr_q;
  assign dcache_r_done = (state_q == ST_DONE) && !wr_q;
  assign fault         = (state_q == ST_DONE) && done_bad;
  assign dcache_r_data = (dcache_r_done && !done_bad)
                         ? load_ext(ram_rdata, align_lane(addr_q[LANE_W-1:0], bits_q), bits_q)
                         : '0;

endmodule

// File: tb/tb_dcache_resp.sv
// Scoreboard bench for dcache_resp: stimulus pushes expected completions, a
// negedge monitor pops and checks type, data, fault and completion cycle.
module tb_dcache_resp;

  localparam int L  = 2;
  localparam int DW = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_rqst = 1'b0, w_rqst = 1'b0;
  logic [63:0] r_addr = '0, w_addr = '0, w_data = '0;
  logic [2:0]  r_bits = '0, w_bits = '0;
  logic        r_done, w_done, flt;
  logic [63:0] r_data;

  typedef struct {
    logic        wr;
    logic [63:0] data;
    logic        flt;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  dcache_resp #(.DEPTH_WORDS(DW), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_r_rqst(r_rqst), .dcache_r_addr(r_addr), .dcache_r_bits(r_bits),
    .dcache_r_done(r_done), .dcache_r_data(r_data),
    .dcache_w_rqst(w_rqst), .dcache_w_addr(w_addr), .dcache_w_bits(w_bits),
    .dcache_w_data(w_data), .dcache_w_done(w_done), .fault(flt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!r_done) chk("r_data_idle_zero", r_data, 64'd0);
    if (!r_done && !w_done) chk("fault_idle_zero", {63'd0, flt}, 64'd0);
    if (r_done || w_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {62'd0, w_done, r_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %s: wr=%0b data=0x%016h fault=%0b cyc=%0d", e.name, w_done, r_data, flt, cyc);
        chk({e.name, "_type"}, {62'd0, w_done, r_done}, e.wr ? 64'd2 : 64'd1);
        if (!e.wr) chk({e.name, "_data"}, r_data, e.data);
        chk({e.name, "_fault"}, {63'd0, flt}, {63'd0, e.flt});
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic expect_op(input logic wr, input logic [63:0] d, input logic f,
                           input int c, input string nm);
    exp_t e;
    e.wr = wr; e.data = d; e.flt = f; e.cyc = c; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_done(input logic wr, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = wr ? w_done : r_done;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic op(input logic wr, input logic [63:0] a, input logic [2:0] b,
                    input logic [63:0] d, input logic [63:0] exp, input logic f,
                    input string nm);
    expect_op(wr, exp, f, cyc + L, nm);
    if (wr) begin
      w_addr = a; w_bits = b; w_data = d; w_rqst = 1'b1;
    end else begin
      r_addr = a; r_bits = b; r_rqst = 1'b1;
    end
    wait_done(wr, nm);
    w_rqst = 1'b0;
    r_rqst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int wd_cnt;
    @(negedge clk);
    #1;
    chk("reset_r_done", {63'd0, r_done}, 64'd0);
    chk("reset_w_done", {63'd0, w_done}, 64'd0);
    chk("reset_fault", {63'd0, flt}, 64'd0);
    chk("reset_r_data", r_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(1, 64'h100, 3'd3, 64'h1122334455667788, 64'd0, 0, "w_dword");
    op(0, 64'h100, 3'd3, 64'd0, 64'h1122334455667788, 0, "r_dword");
    op(0, 64'h107, 3'd0, 64'd0, 64'h0000000000000011, 0, "r_byte_lane7");
    op(0, 64'h100, 3'd0, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, "r_byte_sext");
    op(0, 64'h100, 3'd4, 64'd0, 64'h0000000000000088, 0, "r_byte_zext");
`ifdef DCACHE_MISALIGN_TRAP_EN
    op(0, 64'h102, 3'd2, 64'd0, 64'd0, 1, "r_word_misalign");
    op(0, 64'h100, 3'd7, 64'd0, 64'd0, 1, "r_code7");
    op(1, 64'h101, 3'd3, 64'hDEADDEADDEADDEAD, 64'd0, 1, "w_misalign");
    op(0, 64'h100, 3'd3, 64'd0, 64'h1122334455667788, 0, "r_after_trap_w");
`else
    op(0, 64'h102, 3'd2, 64'd0, 64'h0000000055667788, 0, "r_word_aligndown");
    op(0, 64'h100, 3'd7, 64'd0, 64'h1122334455667788, 0, "r_code7_dword");
`endif
    op(1, 64'h104, 3'd1, 64'h000000000000BEEF, 64'd0, 0, "w_half");
    op(0, 64'h100, 3'd3, 64'd0, 64'h1122BEEF55667788, 0, "r_dword_rmw");
    op(0, 64'h104, 3'd1, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0, "r_half_sext");
    op(0, 64'h104, 3'd5, 64'd0, 64'h000000000000BEEF, 0, "r_half_zext");
    op(1, 64'h10C, 3'd2, 64'h0000000089ABCDEF, 64'd0, 0, "w_word");
    op(0, 64'h10C, 3'd2, 64'd0, 64'hFFFFFFFF89ABCDEF, 0, "r_word_sext");
    op(0, 64'h10C, 3'd6, 64'd0, 64'h0000000089ABCDEF, 0, "r_word_zext");

    // Simultaneous write and read: write wins, read follows LATENCY+1 later.
    expect_op(1, 64'd0, 0, cyc + L, "dual_w");
    expect_op(0, 64'hFFFFFFFFFFFFFFAB, 0, cyc + 2 * L + 1, "dual_r");
    w_addr = 64'h200; w_bits = 3'd0; w_data = 64'hAB; w_rqst = 1'b1;
    r_addr = 64'h200; r_bits = 3'd0; r_rqst = 1'b1;
    wait_done(1, "dual_w");
    w_rqst = 1'b0;
    wait_done(0, "dual_r");
    r_rqst = 1'b0;
    @(negedge clk);

    op(1, 64'h0, 3'd3, 64'hCAFEBABEDEADBEEF, 64'd0, 0, "w_wrap_base");
    op(0, 64'(DW * 8), 3'd3, 64'd0, 64'hCAFEBABEDEADBEEF, 0, "r_wrap_depth");
    op(0, 64'hFFFF000000000000, 3'd3, 64'd0, 64'hCAFEBABEDEADBEEF, 0, "r_wrap_upper");

    // Reset one cycle after accepting a write must abort it.
    op(1, 64'h300, 3'd3, 64'h0102030405060708, 64'd0, 0, "w_prior");
    w_addr = 64'h300; w_bits = 3'd0; w_data = 64'hFF; w_rqst = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    w_rqst = 1'b0;
    #1;
    chk("abort_w_done_in_reset", {63'd0, w_done}, 64'd0);
    chk("abort_fault_in_reset", {63'd0, flt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (w_done) wd_cnt++;
    end
    chk("abort_no_w_done", 64'(wd_cnt), 64'd0);
    op(0, 64'h300, 3'd3, 64'd0, 64'h0102030405060708, 0, "r_after_abort");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
